// File: rtl/bathysphere_sequencer_pkg.sv
// Shared constants for the bathysphere sequencer: state encoding (also read by
// the HEX display decoder), direction values and default timing parameters.
package bathy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'h0,
    ST_ARRIVE     = 4'h1,
    ST_DEPART     = 4'h2,
    ST_FILL       = 4'h3,
    ST_DRAIN      = 4'h4,
    ST_OUTER_OPEN = 4'h5,
    ST_INNER_OPEN = 4'h6,
    ST_DONE       = 4'h7,
    ST_FAULT      = 4'h8
  } state_e;

  localparam logic DIR_DOCK   = 1'b0;
  localparam logic DIR_UNDOCK = 1'b1;

  localparam int DEF_PORT_HOLD_CYCLES = 8;
  localparam int DEF_TIMEOUT_CYCLES   = 64;

  // Largest value the shared counter must hold; the timeout only matters
  // when the watchdog is built in.
  function automatic int cnt_max(int hold, int tmo, bit wd_en);
    return (wd_en && tmo > hold) ? tmo : hold;
  endfunction

endpackage

// File: rtl/bathysphere_sequencer_if.sv
// Request/status/command bundle between the sequencer and its surroundings.
// master = sequencer side, slave = operator logic + interlock side.
interface bathysphere_sequencer_if;
  logic       dock_req;
  logic       undock_req;
  logic       abort;
  logic       chamber_full;
  logic       chamber_empty;
  logic       arrive;
  logic       depart;
  logic       fill;
  logic       drain;
  logic       oport;
  logic       iport;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] state;

  modport master (
    input  dock_req, undock_req, abort, chamber_full, chamber_empty,
    output arrive, depart, fill, drain, oport, iport, busy, done, fault, state
  );

  modport slave (
    output dock_req, undock_req, abort, chamber_full, chamber_empty,
    input  arrive, depart, fill, drain, oport, iport, busy, done, fault, state
  );
endinterface

// File: rtl/bathysphere_sequencer_seq_timer.sv
// Loadable down-counter that sticks at zero; serves both the port hold time
// and the fill/drain watchdog.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)             cnt_q <= '0;
    else if (load_i)         cnt_q <= load_val_i;
    else if (cnt_q != '0)    cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bathysphere_sequencer.sv
// Dock/undock command sequencer for the bathysphere port interlock.
// Define BATHY_SEQ_WATCHDOG_EN to fault on fill/drain taking too long.
module bathysphere_sequencer
  import bathy_pkg::*;
#(
  parameter int PORT_HOLD_CYCLES = DEF_PORT_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  bathysphere_sequencer_if.master  bus
);

`ifdef BATHY_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int CW = $clog2(cnt_max(PORT_HOLD_CYCLES, TIMEOUT_CYCLES, WD_EN) + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(PORT_HOLD_CYCLES - 1);
`ifdef BATHY_SEQ_WATCHDOG_EN
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);
`else
  localparam logic [CW-1:0] TO_LOAD = '0;
`endif

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic          arrive_q, depart_q, fill_q, drain_q, oport_q, iport_q;
  logic          busy_q, done_q, fault_q;
  logic          tmr_zero, tmr_load;
  logic [CW-1:0] tmr_load_val;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.dock_req) begin
          state_d = ST_ARRIVE;
          dir_d   = DIR_DOCK;
        end else if (bus.undock_req) begin
          state_d = ST_DEPART;
          dir_d   = DIR_UNDOCK;
        end
      end
      ST_ARRIVE: state_d = ST_FILL;
      ST_DEPART: state_d = ST_DRAIN;
      ST_FILL: begin
        if (bus.chamber_full) state_d = ST_OUTER_OPEN;
`ifdef BATHY_SEQ_WATCHDOG_EN
        else if (tmr_zero)    state_d = ST_FAULT;
`endif
      end
      ST_DRAIN: begin
        if (bus.chamber_empty) state_d = ST_INNER_OPEN;
`ifdef BATHY_SEQ_WATCHDOG_EN
        else if (tmr_zero)     state_d = ST_FAULT;
`endif
      end
      ST_OUTER_OPEN: if (tmr_zero) state_d = (dir_q == DIR_DOCK) ? ST_DRAIN : ST_DONE;
      ST_INNER_OPEN: if (tmr_zero) state_d = (dir_q == DIR_DOCK) ? ST_DONE  : ST_FILL;
      ST_DONE:       state_d = ST_IDLE;
      ST_FAULT:      state_d = ST_FAULT;
      default:       state_d = ST_IDLE;
    endcase
    // Abort outranks everything; a full+empty reading means the sensors are lying.
    if (state_q != ST_IDLE) begin
      if (bus.abort)                                  state_d = ST_IDLE;
      else if (bus.chamber_full && bus.chamber_empty) state_d = ST_FAULT;
    end
  end

  always_comb begin
    tmr_load_val = '0;
    case (state_d)
      ST_OUTER_OPEN, ST_INNER_OPEN: tmr_load_val = HOLD_LOAD;
      ST_FILL, ST_DRAIN:            tmr_load_val = TO_LOAD;
      default:                      tmr_load_val = '0;
    endcase
  end

  assign tmr_load = (state_d != state_q);

  seq_timer #(.W(CW)) u_timer (
    .gclk       (clock),
    .grst_n     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  // Outputs decode the next state so they line up with the registered state;
  // port commands are gated by the live chamber status as a last safety net.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_DOCK;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      fill_q   <= 1'b0;
      drain_q  <= 1'b0;
      oport_q  <= 1'b0;
      iport_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      arrive_q <= (state_d == ST_ARRIVE);
      depart_q <= (state_d == ST_DEPART);
      fill_q   <= (state_d == ST_FILL);
      drain_q  <= (state_d == ST_DRAIN);
      oport_q  <= (state_d == ST_OUTER_OPEN) && bus.chamber_full;
      iport_q  <= (state_d == ST_INNER_OPEN) && bus.chamber_empty;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign bus.arrive = arrive_q;
  assign bus.depart = depart_q;
  assign bus.fill   = fill_q;
  assign bus.drain  = drain_q;
  assign bus.oport  = oport_q;
  assign bus.iport  = iport_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.fault  = fault_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_bathysphere_sequencer.sv
// Bench for bathysphere_sequencer: a chamber model answers fill/drain, and a
// run-length monitor compares the command stream against queued expectations.
module tb_bathysphere_sequencer;

  localparam int HOLD      = 4;
  localparam int TMO       = 16;
  localparam int FILL_LAT  = 3;
  localparam int DRAIN_LAT = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bathysphere_sequencer_if bus();

  bathysphere_sequencer #(
    .PORT_HOLD_CYCLES (HOLD),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Chamber model: full shows up during the FILL_LAT-th fill cycle, empty
  // during the DRAIN_LAT-th drain cycle.
  logic ch_full = 1'b0, ch_empty = 1'b1;
  logic ld = 1'b0, ld_full = 1'b0, ld_empty = 1'b1, stuck = 1'b0;
  int   fcnt = 0, dcnt = 0;

  assign bus.chamber_full  = ch_full;
  assign bus.chamber_empty = ch_empty;

  always @(posedge clock) begin
    if (ld) begin
      ch_full  <= ld_full;
      ch_empty <= ld_empty;
      fcnt     <= 0;
      dcnt     <= 0;
    end else if (bus.fill && !stuck) begin
      ch_empty <= 1'b0;
      dcnt     <= 0;
      if (fcnt == FILL_LAT - 2) begin ch_full <= 1'b1; fcnt <= 0; end
      else fcnt <= fcnt + 1;
    end else if (bus.drain) begin
      ch_full <= 1'b0;
      fcnt    <= 0;
      if (dcnt == DRAIN_LAT - 2) begin ch_empty <= 1'b1; dcnt <= 0; end
      else dcnt <= dcnt + 1;
    end
  end

  typedef struct { byte c; int n; } tok_t;
  tok_t exp_q[$];

  function automatic byte classify();
    logic [7:0] v;
    v = {bus.arrive, bus.depart, bus.fill, bus.drain,
         bus.oport, bus.iport, bus.done, bus.fault};
    if ($countones(v) > 1) return "?";
    if (bus.arrive) return "A";
    if (bus.depart) return "D";
    if (bus.fill)   return "F";
    if (bus.drain)  return "R";
    if (bus.oport)  return "O";
    if (bus.iport)  return "I";
    if (bus.done)   return "N";
    if (bus.fault)  return "X";
    return 8'd0;
  endfunction

  task automatic push(byte c, int n);
    tok_t t;
    t.c = c;
    t.n = n;
    exp_q.push_back(t);
  endtask

  task automatic sb_cmp(byte c, int n);
    tok_t t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_extra: got %c x%0d, expected no further command", c, n);
    end else begin
      t = exp_q.pop_front();
      if (t.c != c || t.n != n) begin
        errors++;
        $display("FAIL sb_run: got %c x%0d, expected %c x%0d", c, n, t.c, t.n);
      end
    end
  endtask

  byte mon_c;
  byte cur_c = 8'd0;
  int  cur_n = 0;
  int  overlap = 0;

  always @(negedge clock) begin
    mon_c = classify();
    if (bus.oport && bus.iport) overlap++;
    if (mon_c != cur_c) begin
      if (cur_c != 8'd0) sb_cmp(cur_c, cur_n);
      cur_c = mon_c;
      cur_n = 1;
    end else begin
      cur_n++;
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_chamber(logic f, logic e);
    ld_full  = f;
    ld_empty = e;
    ld       = 1'b1;
    tick();
    ld       = 1'b0;
  endtask

  task automatic start(logic dk, logic ud);
    bus.dock_req   = dk;
    bus.undock_req = ud;
    tick();
    bus.dock_req   = 1'b0;
    bus.undock_req = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin tick(); n++; end
    chk(nm, bus.busy, 0);
  endtask

  task automatic wait_sig(string nm, int which);
    int n;
    logic s;
    n = 0;
    s = 1'b0;
    while (n < 60) begin
      case (which)
        0: s = bus.oport;
        1: s = bus.drain;
        default: s = bus.fault;
      endcase
      if (s) break;
      tick();
      n++;
    end
    chk(nm, s, 1);
  endtask

  initial begin
    bus.dock_req   = 1'b0;
    bus.undock_req = 1'b0;
    bus.abort      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_cmds",  {bus.arrive, bus.depart, bus.fill, bus.drain, bus.oport, bus.iport}, 0);
    chk("rst_flags", {bus.done, bus.fault}, 0);
    #3 reset = 1'b1;
    tick();

    // Dock from an empty chamber
    load_chamber(1'b0, 1'b1);
    push("A", 1); push("F", FILL_LAT); push("O", HOLD);
    push("R", DRAIN_LAT); push("I", HOLD); push("N", 1);
    start(1'b1, 1'b0);
    chk("dock_arrive", bus.arrive, 1);
    chk("dock_busy",   bus.busy, 1);
    chk("dock_st_arr", bus.state, 1);
    tick();
    chk("dock_fill",   bus.fill, 1);
    chk("dock_st_fill", bus.state, 3);
    wait_idle("dock_idle");

    // Undock from an empty chamber: drain skips after one cycle
    load_chamber(1'b0, 1'b1);
    push("D", 1); push("R", 1); push("I", HOLD);
    push("F", FILL_LAT); push("O", HOLD); push("N", 1);
    start(1'b0, 1'b1);
    chk("undock_depart", bus.depart, 1);
    wait_idle("undock_idle");

    // Both requests together, chamber already full: dock wins, fill skips
    load_chamber(1'b1, 1'b0);
    push("A", 1); push("F", 1); push("O", HOLD);
    push("R", DRAIN_LAT); push("I", HOLD); push("N", 1);
    start(1'b1, 1'b1);
    chk("both_arrive", bus.arrive, 1);
    chk("both_depart", bus.depart, 0);
    wait_idle("both_idle");

    // Abort on the second outer-port cycle
    load_chamber(1'b0, 1'b1);
    push("A", 1); push("F", FILL_LAT); push("O", 2);
    start(1'b1, 1'b0);
    wait_sig("abort_oport_seen", 0);
    tick();
    chk("abort_oport2", bus.oport, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_oport_off", bus.oport, 0);
    chk("abort_state", bus.state, 0);
    chk("abort_busy",  bus.busy, 0);
    repeat (3) tick();

    // Chamber never reports full
    load_chamber(1'b0, 1'b1);
    stuck = 1'b1;
    push("A", 1);
`ifdef BATHY_SEQ_WATCHDOG_EN
    push("F", TMO); push("X", 1);
    start(1'b1, 1'b0);
    wait_sig("wd_fault", 2);
    chk("wd_cmds",  {bus.arrive, bus.depart, bus.fill, bus.drain, bus.oport, bus.iport, bus.done}, 0);
    chk("wd_state", bus.state, 8);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("wd_clear_state", bus.state, 0);
    chk("wd_clear_fault", bus.fault, 0);
`else
    push("F", 20);
    start(1'b1, 1'b0);
    repeat (20) tick();
    chk("nowd_fill_held", bus.fill, 1);
    chk("nowd_no_fault",  bus.fault, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("nowd_abort_state", bus.state, 0);
`endif
    stuck = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of drain
    load_chamber(1'b0, 1'b1);
    push("A", 1); push("F", FILL_LAT); push("O", HOLD); push("R", 2);
    start(1'b1, 1'b0);
    wait_sig("rstd_drain_seen", 1);
    tick();
    #5 reset = 1'b0;
    #1;
    chk("rstd_drain_off", bus.drain, 0);
    chk("rstd_busy_off",  bus.busy, 0);
    @(posedge clock);
    #2 reset = 1'b1;
    tick();
    chk("rstd_state", bus.state, 0);
    chk("rstd_busy",  bus.busy, 0);

    repeat (3) tick();
    chk("sb_leftover", exp_q.size(), 0);
    chk("port_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
